bin_to_bcd_seq: RTL and testbench

- Iterative shift-and-add-3 (double-dabble) converter that turns the ALU's binary result into packed BCD digits.
- Sits directly upstream of the display cathode driver and feeds its 12-bit BCD_in bus (hundreds/tens/ones nibbles).
- Takes one conversion per start request and holds the result stable for the multiplexed display until the next conversion completes.
- Optional two's-complement mode converts the magnitude and reports the sign separately.

---
 rtl/bin_to_bcd_seq_if.sv | 24 ++
 rtl/bin_to_bcd_seq.sv | 105 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_if.sv
// Conversion request / result bundle between a binary source and the BCD display path.
// The master side issues requests; the converter sits on the slave side.
interface bin_to_bcd_seq_if #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 3
);
   logic                start;
   logic                signed_mode;
   logic [WIDTH-1:0]    bin_in;
   logic [4*DIGITS-1:0] BCD_out;
   logic                neg;
   logic                busy;
   logic                done;

   modport master (
      output start, signed_mode, bin_in,
      input  BCD_out, neg, busy, done
   );

   modport slave (
      input  start, signed_mode, bin_in,
      output BCD_out, neg, busy, done
   );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock.
// The result and sign are held stable between conversions for the display driver.
module bin_to_bcd_seq #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 3
) (
   input logic             clk,
   input logic             reset_n,
   bin_to_bcd_seq_if.slave bus
);
   localparam int unsigned BcdW = 4 * DIGITS;
   localparam int unsigned CntW = $clog2(WIDTH + 1);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    shift_q, shift_d;
   logic [BcdW-1:0]     scratch_q, scratch_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                sign_q, sign_d;
   logic [BcdW-1:0]     bcd_q, bcd_d;
   logic                neg_q, neg_d;
   logic                done_q, done_d;

   logic [BcdW-1:0]       adj;
   logic [BcdW+WIDTH-1:0] shifted;
   logic                  in_neg;
   logic [WIDTH-1:0]      mag;
   logic                  last;

   // Add-3 pre-adjust so each nibble stays a valid decimal digit after the shift.
   always_comb begin
      adj = '0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         adj[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ? scratch_q[4*i +: 4] + 4'd3
                                                       : scratch_q[4*i +: 4];
      end
   end

   assign shifted = {adj, shift_q} << 1;
   assign in_neg  = bus.signed_mode & bus.bin_in[WIDTH-1];
   assign mag     = in_neg ? (~bus.bin_in) + 1'b1 : bus.bin_in;
   assign last    = (cnt_q == CntW'(WIDTH - 1));

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      sign_d    = sign_q;
      bcd_d     = bcd_q;
      neg_d     = neg_q;
      done_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               shift_d   = mag;
               sign_d    = in_neg;
               scratch_d = '0;
               cnt_d     = '0;
               state_d   = StShift;
            end
         end
         StShift: begin
            scratch_d = shifted[BcdW+WIDTH-1:WIDTH];
            shift_d   = shifted[WIDTH-1:0];
            cnt_d     = cnt_q + 1'b1;
            if (last) begin
               bcd_d   = shifted[BcdW+WIDTH-1:WIDTH];
               neg_d   = sign_q;
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         shift_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         sign_q    <= 1'b0;
         bcd_q     <= '0;
         neg_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         sign_q    <= sign_d;
         bcd_q     <= bcd_d;
         neg_q     <= neg_d;
         done_q    <= done_d;
      end
   end

   assign bus.BCD_out = bcd_q;
   assign bus.neg     = neg_q;
   assign bus.busy    = (state_q == StShift);
   assign bus.done    = done_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (WIDTH=8, DIGITS=3).
module tb_bin_to_bcd_seq;
   logic clk;
   logic reset_n;
   int   checks;
   int   failures;

   bin_to_bcd_seq_if #(.WIDTH(8), .DIGITS(3)) bus_if ();

   bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one request, scramble the inputs right after the sample edge, then wait for done.
   task automatic run_conv(input logic [7:0] v, input logic sm, output int lat, output int bsy);
      @(negedge clk);
      bus_if.start       = 1'b1;
      bus_if.bin_in      = v;
      bus_if.signed_mode = sm;
      @(posedge clk);
      #1;
      bus_if.start       = 1'b0;
      bus_if.bin_in      = ~v;
      bus_if.signed_mode = ~sm;
      lat = -1;
      bsy = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (bus_if.busy) bsy++;
         if (bus_if.done) begin
            lat = n - 1;
            break;
         end
      end
   endtask

   initial begin
      int         lat, bsy, bad, dn, t1, t2;
      logic [11:0] v1, v2, exp;

      checks   = 0;
      failures = 0;
      bus_if.start       = 1'b0;
      bus_if.signed_mode = 1'b0;
      bus_if.bin_in      = '0;
      reset_n            = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      chk("reset_bcd",  32'(bus_if.BCD_out), 32'h0);
      chk("reset_flags", {29'd0, bus_if.neg, bus_if.busy, bus_if.done}, 32'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Unsigned 195
      run_conv(8'd195, 1'b0, lat, bsy);
      chk("u195_latency", 32'(lat), 32'd8);
      chk("u195_busy_cycles", 32'(bsy), 32'd8);
      chk("u195_bcd", 32'(bus_if.BCD_out), 32'h195);
      chk("u195_neg", 32'(bus_if.neg), 32'h0);
      @(negedge clk);
      chk("u195_done_one_cycle", 32'(bus_if.done), 32'h0);

      // Hold result during conversion; a start while busy is ignored
      @(negedge clk);
      bus_if.start  = 1'b1;
      bus_if.bin_in = 8'd42;
      @(posedge clk);
      #1 bus_if.start = 1'b0;
      bad = 0;
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (n == 3) begin
            bus_if.start  = 1'b1;
            bus_if.bin_in = 8'd99;
         end
         if (n == 4) bus_if.start = 1'b0;
         if (bus_if.done) begin
            lat = n - 1;
            break;
         end
         if (bus_if.BCD_out !== 12'h195) bad++;
      end
      chk("hold_stable", 32'(bad), 32'd0);
      chk("hold_latency", 32'(lat), 32'd8);
      chk("hold_bcd", 32'(bus_if.BCD_out), 32'h042);
      dn = 0;
      for (int n = 0; n < 15; n++) begin
         @(negedge clk);
         if (bus_if.done || bus_if.busy) dn++;
      end
      chk("ignore_no_second_done", 32'(dn), 32'd0);

      // Extremes
      run_conv(8'd0, 1'b0, lat, bsy);
      chk("u0_bcd", {8'(lat), 12'(bus_if.BCD_out)}, {8'd8, 12'h000});
      run_conv(8'd255, 1'b0, lat, bsy);
      chk("u255_bcd", {8'(lat), 12'(bus_if.BCD_out)}, {8'd8, 12'h255});

      // Full unsigned sweep against decimal digit model
      for (int v = 0; v < 256; v++) begin
         run_conv(8'(v), 1'b0, lat, bsy);
         exp = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
         chk("sweep", {8'(lat), 1'(bus_if.neg), 12'(bus_if.BCD_out)}, {8'd8, 1'b0, exp});
      end

      // Signed mode
      run_conv(8'hFF, 1'b1, lat, bsy);
      chk("s_ff", {3'd0, bus_if.neg, 12'(bus_if.BCD_out)}, {4'd1, 12'h001});
      run_conv(8'h80, 1'b1, lat, bsy);
      chk("s_80", {3'd0, bus_if.neg, 12'(bus_if.BCD_out)}, {4'd1, 12'h128});
      run_conv(8'h00, 1'b1, lat, bsy);
      chk("s_00", {3'd0, bus_if.neg, 12'(bus_if.BCD_out)}, {4'd0, 12'h000});
      run_conv(8'h7F, 1'b1, lat, bsy);
      chk("s_7f", {3'd0, bus_if.neg, 12'(bus_if.BCD_out)}, {4'd0, 12'h127});
      run_conv(8'hFF, 1'b1, lat, bsy);
      run_conv(8'hFF, 1'b0, lat, bsy);
      chk("u_ff_after_signed", {3'd0, bus_if.neg, 12'(bus_if.BCD_out)}, {4'd0, 12'h255});

      // Back-to-back with start held high
      @(negedge clk);
      bus_if.start       = 1'b1;
      bus_if.bin_in      = 8'd10;
      bus_if.signed_mode = 1'b0;
      t1 = -1;
      t2 = -1;
      v1 = '0;
      v2 = '0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (bus_if.done) begin
            if (t1 < 0) begin
               t1 = n;
               v1 = bus_if.BCD_out;
               bus_if.bin_in = 8'd20;
            end else begin
               t2 = n;
               v2 = bus_if.BCD_out;
               bus_if.start = 1'b0;
               break;
            end
         end
      end
      bus_if.start = 1'b0;
      chk("b2b_first_done", 32'(t1), 32'd9);
      chk("b2b_gap", 32'(t2 - t1), 32'd9);
      chk("b2b_bcd1", 32'(v1), 32'h010);
      chk("b2b_bcd2", 32'(v2), 32'h020);

      // Reset in the middle of a conversion
      @(negedge clk);
      bus_if.start  = 1'b1;
      bus_if.bin_in = 8'd200;
      @(posedge clk);
      #1 bus_if.start = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_busy_before_reset", 32'(bus_if.busy), 32'h1);
      reset_n = 1'b0;
      #1;
      chk("mid_reset_bcd", 32'(bus_if.BCD_out), 32'h0);
      chk("mid_reset_flags", {29'd0, bus_if.neg, bus_if.busy, bus_if.done}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      dn  = 0;
      bad = 0;
      for (int n = 0; n < 15; n++) begin
         @(negedge clk);
         if (bus_if.done) dn++;
         if (bus_if.BCD_out !== 12'h000) bad++;
      end
      chk("post_reset_no_done", 32'(dn), 32'd0);
      chk("post_reset_bcd_zero", 32'(bad), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
